// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle mini-cpu controller.
// master = control FSM, slave = datapath side.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             alu_zero;
  logic             mem_ack;
  logic [2:0]       alu_ctrl;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             reg_write;
  logic             mem_to_reg;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  instr, alu_zero, mem_ack,
    output alu_ctrl, alu_src_a, alu_src_b, i_or_d,
    output mem_read, mem_write, ir_write, pc_write,
    output pc_src, reg_write, mem_to_reg, illegal,
    output instret
  );

  modport slave (
    output instr, alu_zero, mem_ack,
    input  alu_ctrl, alu_src_a, alu_src_b, i_or_d,
    input  mem_read, mem_write, ir_write, pc_write,
    input  pc_src, reg_write, mem_to_reg, illegal,
    input  instret
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for an RV32I subset
// (R/I ALU ops, lw, sw, beq) with req/ack memory.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               rst,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ADDR,
    MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH
  } state_t;

  state_t           state, next;
  logic [CNT_W-1:0] cnt;
  logic             retire;

  logic [6:0] op;
  logic [2:0] f3;
  logic       f7b5;
  logic       r_ok, i_ok, ld_ok, st_ok, br_ok;
  logic [2:0] r_ctrl, i_ctrl;

  assign op   = bus.instr[6:0];
  assign f3   = bus.instr[14:12];
  assign f7b5 = bus.instr[30];

  always_comb begin
    r_ok  = (op == 7'b0110011) &&
            (f3 inside {3'b000, 3'b111, 3'b110, 3'b010});
    i_ok  = (op == 7'b0010011) &&
            (f3 inside {3'b000, 3'b111, 3'b110, 3'b010});
    ld_ok = (op == 7'b0000011) && (f3 == 3'b010);
    st_ok = (op == 7'b0100011) && (f3 == 3'b010);
    br_ok = (op == 7'b1100011) && (f3 == 3'b000);
  end

  // funct7[5] only selects SUB for R-type; I-type imm bits must not leak in
  always_comb begin
    i_ctrl = 3'b010;
    case (f3)
      3'b111:  i_ctrl = 3'b000;
      3'b110:  i_ctrl = 3'b001;
      3'b010:  i_ctrl = 3'b111;
      default: i_ctrl = 3'b010;
    endcase
    r_ctrl = i_ctrl;
    if (f3 == 3'b000 && f7b5)
      r_ctrl = 3'b110;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= next;
      if (retire)
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.instret = cnt;

  always_comb begin
    next           = state;
    retire         = 1'b0;
    bus.alu_ctrl   = 3'b000;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.illegal    = 1'b0;
    if (!rst) begin
      unique case (state)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.alu_ctrl  = 3'b010;
          if (bus.mem_ack) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            next         = DECODE;
          end
        end
        DECODE: begin
          unique case (1'b1)
            r_ok:          next = EXEC_R;
            i_ok:          next = EXEC_I;
            ld_ok, st_ok:  next = ADDR;
            br_ok:         next = BRANCH;
            default: begin
              bus.illegal = 1'b1;
              next        = FETCH;
            end
          endcase
        end
        EXEC_R: begin
          bus.alu_src_a = 1'b1;
          bus.alu_ctrl  = r_ctrl;
          next          = WB_ALU;
        end
        EXEC_I: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_ctrl  = i_ctrl;
          next          = WB_ALU;
        end
        ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_ctrl  = 3'b010;
          next          = bus.instr[5] ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
          if (bus.mem_ack)
            next = WB_MEM;
        end
        MEM_WR: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
          if (bus.mem_ack) begin
            retire = 1'b1;
            next   = FETCH;
          end
        end
        WB_ALU: begin
          bus.reg_write = 1'b1;
          retire        = 1'b1;
          next          = FETCH;
        end
        WB_MEM: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          retire         = 1'b1;
          next           = FETCH;
        end
        BRANCH: begin
          bus.alu_src_a = 1'b1;
          bus.alu_ctrl  = 3'b110;
          bus.pc_write  = bus.alu_zero;
          bus.pc_src    = 1'b1;
          retire        = 1'b1;
          next          = FETCH;
        end
        default: next = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction
// cycle model compared every cycle, plus literal pins.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) ifc ();
  multicycle_control_if #(.CNT_W(2))  ifc2 ();

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(ifc.master)
  );
  multicycle_control #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(ifc2.master)
  );

  assign ifc2.instr    = ifc.instr;
  assign ifc2.alu_zero = ifc.alu_zero;
  assign ifc2.mem_ack  = ifc.mem_ack;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          rd_cnt = 0;
  logic [31:0] n_ret = 0;
  logic [14:0] exp_o = '0;
  logic [31:0] exp_cnt = 0;
  bit          check_en = 0;

  function automatic logic [14:0] mk(
    logic [2:0] c, logic a, logic [1:0] b,
    logic iod, logic rd, logic wr, logic irw, logic pcw,
    logic pcs, logic rw, logic m2r, logic ill);
    return {c, a, b, iod, rd, wr, irw, pcw, pcs, rw, m2r, ill};
  endfunction

  function automatic logic [14:0] pack1();
    return {ifc.alu_ctrl, ifc.alu_src_a, ifc.alu_src_b,
            ifc.i_or_d, ifc.mem_read, ifc.mem_write,
            ifc.ir_write, ifc.pc_write, ifc.pc_src,
            ifc.reg_write, ifc.mem_to_reg, ifc.illegal};
  endfunction

  function automatic logic [14:0] pack2();
    return {ifc2.alu_ctrl, ifc2.alu_src_a, ifc2.alu_src_b,
            ifc2.i_or_d, ifc2.mem_read, ifc2.mem_write,
            ifc2.ir_write, ifc2.pc_write, ifc2.pc_src,
            ifc2.reg_write, ifc2.mem_to_reg, ifc2.illegal};
  endfunction

  task automatic chk(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
  endtask

  // every-cycle comparison against the bench model
  always @(negedge clk) begin
    if (check_en) begin
      logic [14:0] a1, a2;
      logic [1:0]  w2;
      a1 = pack1();
      a2 = pack2();
      w2 = exp_cnt[1:0];
      if (ifc.mem_read && ifc.i_or_d) rd_cnt++;
      total += 4;
      if (a1 !== exp_o) begin
        bad++;
        $display("FAIL outs t=%0t got=%h want=%h", $time, a1, exp_o);
      end
      if (ifc.instret !== exp_cnt) begin
        bad++;
        $display("FAIL instret t=%0t got=%0d want=%0d",
                 $time, ifc.instret, exp_cnt);
      end
      if (a2 !== exp_o) begin
        bad++;
        $display("FAIL outs2 t=%0t got=%h want=%h", $time, a2, exp_o);
      end
      if (ifc2.instret !== w2) begin
        bad++;
        $display("FAIL instret2 t=%0t got=%0d want=%0d",
                 $time, ifc2.instret, w2);
      end
    end
  end

  task automatic step(input logic [14:0] e, input logic ack,
                      input logic zero, input bit ret);
    ifc.mem_ack  = ack;
    ifc.alu_zero = zero;
    exp_o        = e;
    exp_cnt      = n_ret;
    cyc++;
    @(negedge clk);
    @(posedge clk);
    #1;
    if (rst) n_ret = 0;
    else if (ret) n_ret = n_ret + 1;
    ifc.mem_ack  = 1'b0;
    ifc.alu_zero = 1'b0;
  endtask

  task automatic run(input logic [31:0] ins, input int fw,
                     input int mw, input logic zero, input logic stray);
    logic [6:0] op;
    logic [2:0] f3;
    logic [2:0] c;
    bit is_r, is_i, ld, st, br;
    ifc.instr = ins;
    op = ins[6:0];
    f3 = ins[14:12];
    cyc = 0;
    for (int i = 0; i < fw; i++)
      step(mk(3'b010, 0, 2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0);
    step(mk(3'b010, 0, 2'b01, 0, 1, 0, 1, 1, 0, 0, 0, 0), 1, 0, 0);
    is_r = (op == 7'h33) && (f3 inside {3'd0, 3'd7, 3'd6, 3'd2});
    is_i = (op == 7'h13) && (f3 inside {3'd0, 3'd7, 3'd6, 3'd2});
    ld   = (op == 7'h03) && (f3 == 3'd2);
    st   = (op == 7'h23) && (f3 == 3'd2);
    br   = (op == 7'h63) && (f3 == 3'd0);
    if (!(is_r || is_i || ld || st || br)) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), stray, 0, 0);
      return;
    end
    step('0, stray, 0, 0);
    case (f3)
      3'd7:    c = 3'b000;
      3'd6:    c = 3'b001;
      3'd2:    c = 3'b111;
      default: c = (is_r && ins[30]) ? 3'b110 : 3'b010;
    endcase
    if (is_r || is_i) begin
      step(mk(c, 1, is_r ? 2'b00 : 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0),
           stray, 0, 0);
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), stray, 0, 1);
    end else if (br) begin
      step(mk(3'b110, 1, 2'b00, 0, 0, 0, 0, zero, 1, 0, 0, 0),
           stray, zero, 1);
    end else begin
      step(mk(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0), stray, 0, 0);
      for (int i = 0; i < mw; i++)
        step(mk(0, 0, 0, 1, ld, st, 0, 0, 0, 0, 0, 0), 0, 0, 0);
      step(mk(0, 0, 0, 1, ld, st, 0, 0, 0, 0, 0, 0), 1, 0, st);
      if (ld)
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), stray, 0, 1);
    end
  endtask

  initial begin
    ifc.instr    = '0;
    ifc.mem_ack  = 1'b0;
    ifc.alu_zero = 1'b0;
    @(posedge clk);
    #1;
    check_en = 1;
    step('0, 1, 0, 0);
    step('0, 0, 0, 0);
    rst = 1'b0;

    run(32'h002081B3, 0, 0, 0, 0);
    chk("add_cycles", cyc, 4);
    chk("add_instret", ifc.instret, 1);
    run(32'h402081B3, 0, 0, 0, 0);
    run(32'h0020A193, 0, 0, 0, 0);
    chk("sub_slti_instret", ifc.instret, 3);

    rd_cnt = 0;
    run(32'h0000A183, 0, 3, 0, 0);
    chk("lw_cycles", cyc, 8);
    chk("lw_mem_read_hold", rd_cnt, 4);

    run(32'h0020A023, 1, 2, 0, 1);
    chk("sw_cycles", cyc, 7);

    run(32'h00208463, 0, 0, 1, 0);
    chk("beq_cycles", cyc, 3);
    run(32'h00208463, 0, 0, 0, 0);
    chk("beq_instret", ifc.instret, 7);

    run(32'h0000007F, 0, 0, 0, 1);
    chk("ill_op_cycles", cyc, 2);
    run(32'h002091B3, 0, 0, 0, 0);
    chk("ill_f3_instret", ifc.instret, 7);

    run(32'h0070F193, 2, 0, 0, 1);
    run(32'h0070E193, 0, 0, 0, 0);
    run(32'h0020F1B3, 0, 0, 0, 0);
    run(32'h0020E1B3, 0, 0, 0, 0);
    run(32'hFFF08193, 0, 0, 0, 0);
    chk("alu_mix_instret", ifc.instret, 12);
    run(32'h0020A023, 0, 0, 0, 0);
    chk("sw_fast_cycles", cyc, 4);

    // reset lands mid MEM_WR wait
    ifc.instr = 32'h0020A023;
    step(mk(3'b010, 0, 2'b01, 0, 1, 0, 1, 1, 0, 0, 0, 0), 1, 0, 0);
    step('0, 0, 0, 0);
    step(mk(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0);
    step(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0);
    step(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0);
    rst = 1'b1;
    step('0, 1, 0, 0);
    rst = 1'b0;
    chk("rst_instret", ifc.instret, 0);
    run(32'h002081B3, 0, 0, 0, 0);
    chk("post_rst_instret", ifc.instret, 1);

    check_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
